// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: redirect codes, FSM
// state encodings, default reset PC and small datapath helpers that mirror
// the decode-side sign_extend / shift_left_2 / adder_32b blocks.
package fetch_stage_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'b00,
    REDIR_BR   = 2'b01,
    REDIR_J    = 2'b10,
    REDIR_JR   = 2'b11
  } redir_type_e;

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } fetch_state_e;

  // 16-bit branch immediate to 32-bit two's complement
  function automatic logic [31:0] sign_extend(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  // Word offset to byte offset; the top two bits fall off (mod 2^32)
  function automatic logic [31:0] shift_left_2(input logic [31:0] val);
    return val << 2;
  endfunction

  // 32-bit wrapping adder
  function automatic logic [31:0] adder_32b(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle around the fetch stage: instruction-memory request/response,
// control-flow redirect input and the valid/ready hand-off to decode.
// master = fetch stage side, slave = memory / decode / execute side.
interface fetch_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;

  logic              redir_valid;
  logic [1:0]        redir_type;
  logic [ADDR_W-1:0] redir_pc4;
  logic [25:0]       redir_imm;
  logic [ADDR_W-1:0] redir_reg;

  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc4;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redir_valid, redir_type, redir_pc4, redir_imm, redir_reg,
    output if_valid, if_instr, if_pc4,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redir_valid, redir_type, redir_pc4, redir_imm, redir_reg,
    input  if_valid, if_instr, if_pc4,
    output if_ready
  );

endinterface

// File: rtl/fetch_stage_next_pc.sv
// fetch_next_pc: combinational next-PC helper. Produces the sequential PC
// (pc+4) and, for a valid redirect, the branch / jump / jr target.
module fetch_next_pc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_redir_valid,
  input  logic [1:0]  i_redir_type,
  input  logic [31:0] i_redir_pc4,
  input  logic [25:0] i_redir_imm,
  input  logic [31:0] i_redir_reg,
  output logic [31:0] o_pc_plus4,
  output logic        o_redir_take,
  output logic [31:0] o_redir_target
);

  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_jr_target;
  logic        w_unused_reg_lsb;

  assign o_pc_plus4       = adder_32b(i_pc, 32'd4);
  assign w_br_target      = adder_32b(i_redir_pc4, shift_left_2(sign_extend(i_redir_imm[15:0])));
  assign w_j_target       = {i_redir_pc4[31:28], i_redir_imm, 2'b00};
  // jr forces word alignment, the register's two LSBs are discarded
  assign w_jr_target      = {i_redir_reg[31:2], 2'b00};
  assign w_unused_reg_lsb = ^i_redir_reg[1:0];

  // Select the redirect target; type NONE never redirects
  always_comb begin
    o_redir_take   = 1'b0;
    o_redir_target = i_pc;
    if (i_redir_valid) begin
      case (redir_type_e'(i_redir_type))
        REDIR_BR: begin
          o_redir_take   = 1'b1;
          o_redir_target = w_br_target;
        end
        REDIR_J: begin
          o_redir_take   = 1'b1;
          o_redir_target = w_j_target;
        end
        REDIR_JR: begin
          o_redir_take   = 1'b1;
          o_redir_target = w_jr_target;
        end
        default: begin
          o_redir_take   = 1'b0;
          o_redir_target = i_pc;
        end
      endcase
    end else begin
      o_redir_take   = 1'b0;
      o_redir_target = i_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, single-outstanding fetch FSM (REQ/WAIT/HOLD),
// registered hand-off to decode and a drop flag that discards a response
// whose request was overtaken by a redirect.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       DATA_W   = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_req_valid;
  logic              r_drop;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_if_instr;
  logic [ADDR_W-1:0] r_if_pc4;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic              w_redir_take;
  logic [ADDR_W-1:0] w_redir_target;

  fetch_next_pc u_next_pc (
    .i_pc           (r_pc),
    .i_redir_valid  (bus.redir_valid),
    .i_redir_type   (bus.redir_type),
    .i_redir_pc4    (bus.redir_pc4),
    .i_redir_imm    (bus.redir_imm),
    .i_redir_reg    (bus.redir_reg),
    .o_pc_plus4     (w_pc_plus4),
    .o_redir_take   (w_redir_take),
    .o_redir_target (w_redir_target)
  );

  assign bus.imem_req_valid = r_req_valid;
  assign bus.imem_addr      = r_pc;
  assign bus.if_valid       = r_if_valid;
  assign bus.if_instr       = r_if_instr;
  assign bus.if_pc4         = r_if_pc4;

  // Fetch FSM with PC, drop flag and decode output registers; redirect wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_REQ;
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_drop      <= 1'b0;
      r_if_valid  <= 1'b0;
      r_if_instr  <= {DATA_W{1'b0}};
      r_if_pc4    <= {ADDR_W{1'b0}};
    end else if (w_redir_take) begin
      r_pc       <= w_redir_target;
      r_if_valid <= 1'b0;
      case (r_state)
        ST_REQ: begin
          // a request accepted this cycle is in flight; its data is stale
          if (r_req_valid && bus.imem_req_ready) begin
            r_state     <= ST_WAIT;
            r_req_valid <= 1'b0;
            r_drop      <= 1'b1;
          end else begin
            r_req_valid <= 1'b1;
          end
        end
        ST_WAIT: begin
          // response arriving on the redirect cycle is simply discarded
          if (bus.imem_rsp_valid) begin
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
            r_drop      <= 1'b0;
          end else begin
            r_drop      <= 1'b1;
          end
        end
        ST_HOLD: begin
          r_state     <= ST_REQ;
          r_req_valid <= 1'b1;
        end
        default: begin
          r_state     <= ST_REQ;
          r_req_valid <= 1'b1;
          r_drop      <= 1'b0;
        end
      endcase
    end else begin
      case (r_state)
        ST_REQ: begin
          if (r_req_valid && bus.imem_req_ready) begin
            r_state     <= ST_WAIT;
            r_req_valid <= 1'b0;
          end else begin
            r_req_valid <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (r_drop) begin
              r_drop      <= 1'b0;
              r_state     <= ST_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_if_instr  <= bus.imem_rsp_data;
              r_if_pc4    <= w_pc_plus4;
              r_if_valid  <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (r_if_valid && bus.if_ready) begin
            r_pc        <= w_pc_plus4;
            r_if_valid  <= 1'b0;
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state     <= ST_REQ;
          r_req_valid <= 1'b1;
          r_drop      <= 1'b0;
          r_if_valid  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;

  // Count decode acceptances (not ones killed by a redirect) and stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= 32'd0;
      r_perf_stall   <= 32'd0;
    end else begin
      if (r_if_valid && bus.if_ready && !w_redir_take) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end else begin
        r_perf_fetched <= r_perf_fetched;
      end
      if (r_if_valid && !bus.if_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end else begin
        r_perf_stall <= r_perf_stall;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. Inputs change 1 time unit
// after the rising edge and outputs are sampled at that same point.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_perf(input string tag, input logic [31:0] exp_fetched, input logic [31:0] exp_stall);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_fetched"}, perf_fetched, exp_fetched);
    check({tag, "_stall"}, perf_stall, exp_stall);
`else
    if (tag.len() == 0) $display("perf %h %h", exp_fetched, exp_stall);
`endif
  endtask

  // In REQ with the request up: check address, handshake it, land in WAIT
  task automatic issue(input logic [31:0] exp_addr);
    check("req_valid_req", {31'd0, bus.imem_req_valid}, 32'd1);
    check("imem_addr", bus.imem_addr, exp_addr);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    check("req_valid_wait", {31'd0, bus.imem_req_valid}, 32'd0);
  endtask

  task automatic respond(input logic [31:0] data);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    step();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0000_0000;
  endtask

  task automatic expect_if(input logic [31:0] instr, input logic [31:0] pc4);
    check("if_valid", {31'd0, bus.if_valid}, 32'd1);
    check("if_instr", bus.if_instr, instr);
    check("if_pc4", bus.if_pc4, pc4);
  endtask

  task automatic accept();
    bus.if_ready = 1'b1;
    step();
    bus.if_ready = 1'b0;
    check("if_valid_after_acc", {31'd0, bus.if_valid}, 32'd0);
  endtask

  task automatic redirect(input logic [1:0] typ, input logic [31:0] pc4,
                          input logic [25:0] imm, input logic [31:0] rreg);
    bus.redir_valid = 1'b1;
    bus.redir_type  = typ;
    bus.redir_pc4   = pc4;
    bus.redir_imm   = imm;
    bus.redir_reg   = rreg;
  endtask

  task automatic clear_redirect();
    bus.redir_valid = 1'b0;
    bus.redir_type  = 2'b00;
    bus.redir_pc4   = 32'h0000_0000;
    bus.redir_imm   = 26'h000_0000;
    bus.redir_reg   = 32'h0000_0000;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0000_0000;
    bus.if_ready       = 1'b0;
    clear_redirect();

    // reset state
    step();
    step();
    check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("rst_if_instr", bus.if_instr, 32'h0000_0000);
    check("rst_if_pc4", bus.if_pc4, 32'h0000_0000);
    check("rst_addr", bus.imem_addr, 32'h0000_0000);
    check_perf("rst_perf", 32'd0, 32'd0);

    rst_n = 1'b1;
    step();

    // sequential fetches 0, 4, 8
    issue(32'h0000_0000);
    respond(32'h2002_0005);
    expect_if(32'h2002_0005, 32'h0000_0004);
    accept();
    issue(32'h0000_0004);
    respond(32'h2003_0001);
    expect_if(32'h2003_0001, 32'h0000_0008);
    accept();
    issue(32'h0000_0008);
    respond(32'h8C01_0000);
    expect_if(32'h8C01_0000, 32'h0000_000C);

    // decode stalls for 3 cycles: output held, no new request
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_if_valid", {31'd0, bus.if_valid}, 32'd1);
      check("stall_if_instr", bus.if_instr, 32'h8C01_0000);
      check("stall_if_pc4", bus.if_pc4, 32'h0000_000C);
      check("stall_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    end
    check_perf("stall_perf", 32'd2, 32'd3);
    accept();
    check_perf("after_stall_perf", 32'd3, 32'd3);

    // branch in REQ: 0x100 + sext(0xFFFE)<<2 = 0xF8
    redirect(2'b01, 32'h0000_0100, 26'h000_FFFE, 32'h0000_0000);
    step();
    clear_redirect();
    issue(32'h0000_00F8);
    respond(32'h1234_5678);
    expect_if(32'h1234_5678, 32'h0000_00FC);
    accept();
    check("seq_after_branch", bus.imem_addr, 32'h0000_00FC);

    // jump: {0x4, 26'h10, 00} = 0x4000_0040
    redirect(2'b10, 32'h4000_0010, 26'h000_0010, 32'h0000_0000);
    step();
    clear_redirect();

    // jr while a request is pending: response must be dropped
    issue(32'h4000_0040);
    redirect(2'b11, 32'h0000_0000, 26'h000_0000, 32'h0000_1237);
    step();
    clear_redirect();
    check("wait_redir_addr", bus.imem_addr, 32'h0000_1234);
    check("wait_redir_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    respond(32'hDEAD_BEEF);
    check("dropped_if_valid", {31'd0, bus.if_valid}, 32'd0);
    issue(32'h0000_1234);
    respond(32'hCAFE_0001);
    expect_if(32'hCAFE_0001, 32'h0000_1238);

    // redirect and if_ready together in HOLD: instruction killed
    bus.if_ready = 1'b1;
    redirect(2'b01, 32'h0000_2000, 26'h000_0004, 32'h0000_0000);
    step();
    bus.if_ready = 1'b0;
    clear_redirect();
    check("hold_redir_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check_perf("hold_redir_perf", 32'd4, 32'd3);
    issue(32'h0000_2010);
    respond(32'h0000_0000);
    expect_if(32'h0000_0000, 32'h0000_2014);
    accept();

    // PC wrap at the top of the address space
    redirect(2'b11, 32'h0000_0000, 26'h000_0000, 32'hFFFF_FFFF);
    step();
    clear_redirect();
    issue(32'hFFFF_FFFC);
    respond(32'h0BAD_F00D);
    expect_if(32'h0BAD_F00D, 32'h0000_0000);
    accept();
    issue(32'h0000_0000);
    respond(32'h2002_0005);
    expect_if(32'h2002_0005, 32'h0000_0004);
    accept();

    // redirect type 00 is ignored
    redirect(2'b00, 32'h0000_0300, 26'h000_0040, 32'h0000_0400);
    step();
    clear_redirect();
    check("none_redir_addr", bus.imem_addr, 32'h0000_0004);
    check_perf("pre_reset_perf", 32'd7, 32'd3);

    // async reset in the middle of WAIT
    issue(32'h0000_0004);
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("midrst_addr", bus.imem_addr, 32'h0000_0000);
    check("midrst_if_pc4", bus.if_pc4, 32'h0000_0000);
    check("midrst_if_instr", bus.if_instr, 32'h0000_0000);
    check_perf("midrst_perf", 32'd0, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    issue(32'h0000_0000);
    respond(32'h2002_0005);
    expect_if(32'h2002_0005, 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
